// File: rtl/wb_pkg.sv
// Shared Wishbone definitions for the RAM slave and its storage array.
// Holds bus widths, the poison word returned for illegal reads when error
// termination is compiled out, the slave FSM states and the latched request.
package wb_pkg;
  localparam int WB_DATA_W = 32;
  localparam int WB_SEL_W  = 4;

  localparam logic [WB_DATA_W-1:0] WB_POISON = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP, ST_HOLD} wb_state_e;

  // Source of the read-data output register.
  typedef enum logic [1:0] {DSRC_ZERO, DSRC_RAM, DSRC_POISON} wb_dsrc_e;

  typedef struct packed {
    logic                 we;
    logic [WB_SEL_W-1:0]  sel;
    logic [31:0]          adr;
    logic [WB_DATA_W-1:0] dat;
  } wb_req_t;
endpackage

// File: rtl/wb_ram_array.sv
// Synchronous single-port RAM with per-byte write enables, write-first.
// No reset: contents and the read register power up undefined.
// Ports:
//   clk_i    clock
//   we_i     write strobe; lanes gated by sel_i
//   re_i     read strobe; updates rdata_o, which holds otherwise
//   sel_i    byte lane enables (bit n = data[8n+7:8n])
//   addr_i   word index
//   wdata_i  write data
//   rdata_o  registered read data
module wb_ram_array
  import wb_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic                 re_i,
  input  logic [WB_SEL_W-1:0]  sel_i,
  input  logic [AW-1:0]        addr_i,
  input  logic [WB_DATA_W-1:0] wdata_i,
  output logic [WB_DATA_W-1:0] rdata_o
);
  logic [WB_SEL_W-1:0][7:0] wlane;
  assign wlane = wdata_i;

  for (genvar l = 0; l < WB_SEL_W; l++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] rd_q;

    // Same-cycle read of a lane being written returns the new byte.
    always_ff @(posedge clk_i) begin
      if (we_i && sel_i[l]) mem[addr_i] <= wlane[l];
      if (re_i) rd_q <= (we_i && sel_i[l]) ? wlane[l] : mem[addr_i];
    end

    assign rdata_o[8*l +: 8] = rd_q;
  end
endmodule

// File: rtl/wb_ram_slave.sv
// Wishbone B4 classic RAM slave with byte-lane writes and wait states.
// Optional macro WB_RAM_SLAVE_ERR_EN: when defined, illegal accesses end with
// wb_err_o; otherwise they end with wb_ack_o, writes are dropped and reads
// return WB_POISON. Timing is the same in both builds.
// Ports:
//   clk_i, rst_i           clock, async active-high reset
//   wb_cyc_i, wb_stb_i     cycle / strobe
//   wb_we_i, wb_sel_i      write enable, byte lanes
//   wb_adr_i, wb_dat_i     byte address, write data
//   wb_dat_o               read data, held until the next read is answered
//   wb_ack_o, wb_err_o     one-cycle termination pulses
module wb_ram_slave
  import wb_pkg::*;
#(
  parameter int          MEM_WORDS   = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o
);
  localparam int          AW        = $clog2(MEM_WORDS);
  localparam logic [31:0] SPAN_MASK = 32'(4 * MEM_WORDS - 1);
  localparam logic [3:0]  CNT_INIT  = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  wb_state_e            state_q, state_d;
  wb_req_t              req_q;
  logic [3:0]           cnt_q;
  logic                 ack_q;
  wb_dsrc_e             dsrc_q;
  logic                 req_vld, legal, resp, ack_d, ram_we, ram_re;
  logic [WB_DATA_W-1:0] ram_rdata;

  assign req_vld = wb_cyc_i & wb_stb_i;
  // BASE_ADDR is aligned to the window size, so a mask compare is a range check.
  assign legal   = ((req_q.adr & ~SPAN_MASK) == BASE_ADDR) && (req_q.adr[1:0] == 2'b00);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_vld) state_d = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT: begin
        if (!wb_cyc_i)        state_d = ST_IDLE;
        else if (cnt_q == '0) state_d = ST_RESP;
      end
      // A strobe withdrawn before the response is treated as an abort.
      ST_RESP: state_d = req_vld ? ST_HOLD : ST_IDLE;
      // Wait for stb to fall so one strobe never collects two acks.
      ST_HOLD: if (!wb_stb_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    resp   = (state_q == ST_RESP) && req_vld;
    ram_we = resp && legal && req_q.we;
    ram_re = resp && legal && !req_q.we;
`ifdef WB_RAM_SLAVE_ERR_EN
    ack_d  = resp && legal;
`else
    ack_d  = resp;
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_q  <= '0;
      cnt_q  <= '0;
      ack_q  <= 1'b0;
      dsrc_q <= DSRC_ZERO;
    end else begin
      if (state_q == ST_IDLE && req_vld) begin
        req_q <= '{we: wb_we_i, sel: wb_sel_i, adr: wb_adr_i, dat: wb_dat_i};
        cnt_q <= CNT_INIT;
      end else if (state_q == ST_WAIT && cnt_q != '0) begin
        cnt_q <= cnt_q - 4'd1;
      end
      ack_q <= ack_d;
      if (ram_re) dsrc_q <= DSRC_RAM;
`ifndef WB_RAM_SLAVE_ERR_EN
      else if (resp && !legal && !req_q.we) dsrc_q <= DSRC_POISON;
`endif
    end
  end

`ifdef WB_RAM_SLAVE_ERR_EN
  logic err_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= resp && !legal;
  end
  assign wb_err_o = err_q;
`else
  assign wb_err_o = 1'b0;
`endif

  assign wb_ack_o = ack_q;

  always_comb begin
    case (dsrc_q)
      DSRC_RAM:    wb_dat_o = ram_rdata;
      DSRC_POISON: wb_dat_o = WB_POISON;
      default:     wb_dat_o = '0;
    endcase
  end

  wb_ram_array #(.DEPTH(MEM_WORDS), .AW(AW)) u_ram (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .sel_i   (req_q.sel),
    .addr_i  (req_q.adr[AW+1:2]),
    .wdata_i (req_q.dat),
    .rdata_o (ram_rdata)
  );
endmodule

// File: tb/tb_wb_ram_slave.sv
module tb_wb_ram_slave;
`ifdef WB_RAM_SLAVE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Index 0: WAIT_STATES = 1, index 1: WAIT_STATES = 3.
  logic        cyc [2];
  logic        stb [2];
  logic        we  [2];
  logic [3:0]  sel [2];
  logic [31:0] adr [2];
  logic [31:0] wd  [2];
  logic [31:0] rd  [2];
  logic        ack [2];
  logic        err [2];

  wb_ram_slave #(.MEM_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(1)) dut_ws1 (
    .clk_i(clk), .rst_i(rst), .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]), .wb_we_i(we[0]),
    .wb_sel_i(sel[0]), .wb_adr_i(adr[0]), .wb_dat_i(wd[0]), .wb_dat_o(rd[0]),
    .wb_ack_o(ack[0]), .wb_err_o(err[0]));

  wb_ram_slave #(.MEM_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(3)) dut_ws3 (
    .clk_i(clk), .rst_i(rst), .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]), .wb_we_i(we[1]),
    .wb_sel_i(sel[1]), .wb_adr_i(adr[1]), .wb_dat_i(wd[1]), .wb_dat_o(rd[1]),
    .wb_ack_o(ack[1]), .wb_err_o(err[1]));

  int vecs = 0;
  int miss = 0;

  // Results of the last transfer.
  int          r_lat;
  logic        r_ack, r_err, r_after;
  logic [31:0] r_dat;
  int          r_extra;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle(input int d);
    cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
    sel[d] = 4'h0; adr[d] = 32'h0; wd[d] = 32'h0;
  endtask

  // Issue one request, wait (bounded) for termination, optionally keep stb up
  // for extra cycles, then release the bus for one cycle.
  task automatic xfer(input int d, input bit w, input logic [31:0] a,
                      input logic [31:0] data, input logic [3:0] s, input int hold);
    bit got = 0;
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; wd[d] = data; sel[d] = s;
    r_lat = 0;
    while (!got && r_lat < 40) begin
      tick();
      r_lat++;
      if (ack[d] || err[d]) got = 1;
    end
    r_ack = ack[d]; r_err = err[d]; r_dat = rd[d];
    r_extra = 0;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (ack[d] || err[d]) r_extra++;
    end
    bus_idle(d);
    tick();
    r_after = ack[d] | err[d];
  endtask

  initial begin
    bus_idle(0);
    bus_idle(1);
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (5) tick();
    chk("reset_ack", {31'b0, ack[0]}, 32'h0);
    chk("reset_err", {31'b0, err[0]}, 32'h0);
    chk("reset_dat", rd[0], 32'h0);

    // Basic write/read, WAIT_STATES = 1: ack two edges after the sampling edge.
    xfer(0, 1'b1, 32'h10, 32'hA5A5_1234, 4'hF, 0);
    chk("wr_latency", 32'(r_lat), 32'd3);
    chk("wr_ack", {31'b0, r_ack}, 32'h1);
    chk("wr_err", {31'b0, r_err}, 32'h0);
    chk("wr_pulse_end", {31'b0, r_after}, 32'h0);
    xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, 0);
    chk("rd_latency", 32'(r_lat), 32'd3);
    chk("rd_ack", {31'b0, r_ack}, 32'h1);
    chk("rd_data", r_dat, 32'hA5A5_1234);
    chk("rd_pulse_end", {31'b0, r_after}, 32'h0);
    chk("rd_data_held", rd[0], 32'hA5A5_1234);

    // Byte lanes.
    xfer(0, 1'b1, 32'h20, 32'h1122_3344, 4'hF, 0);
    xfer(0, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'b0101, 0);
    xfer(0, 1'b0, 32'h20, 32'h0, 4'hF, 0);
    chk("lane_merge", r_dat, 32'h11FF_33FF);
    xfer(0, 1'b1, 32'h20, 32'h0000_0000, 4'h0, 0);
    chk("sel0_ack", {31'b0, r_ack}, 32'h1);
    xfer(0, 1'b0, 32'h20, 32'h0, 4'hF, 0);
    chk("sel0_nowrite", r_dat, 32'h11FF_33FF);

    // Illegal accesses: out of range (would alias word 0) and misaligned.
    xfer(0, 1'b1, 32'h0, 32'h00C0_FFEE, 4'hF, 0);
    xfer(0, 1'b1, 32'h1000, 32'h1234_5678, 4'hF, 0);
    chk("oor_wr_ack", {31'b0, r_ack}, ERR_EN ? 32'h0 : 32'h1);
    chk("oor_wr_err", {31'b0, r_err}, ERR_EN ? 32'h1 : 32'h0);
    chk("oor_wr_pulse_end", {31'b0, r_after}, 32'h0);
    xfer(0, 1'b0, 32'h0, 32'h0, 4'hF, 0);
    chk("oor_wr_noalias", r_dat, 32'h00C0_FFEE);
    xfer(0, 1'b0, 32'h1000, 32'h0, 4'hF, 0);
    chk("oor_rd_err", {31'b0, r_err}, ERR_EN ? 32'h1 : 32'h0);
    chk("oor_rd_data", r_dat, ERR_EN ? 32'h00C0_FFEE : 32'hDEAD_BEEF);
    xfer(0, 1'b0, 32'h22, 32'h0, 4'hF, 0);
    chk("mis_rd_ack", {31'b0, r_ack}, ERR_EN ? 32'h0 : 32'h1);
    chk("mis_rd_data", r_dat, ERR_EN ? 32'h00C0_FFEE : 32'hDEAD_BEEF);
    xfer(0, 1'b1, 32'h22, 32'h0000_0000, 4'hF, 0);
    chk("mis_wr_err", {31'b0, r_err}, ERR_EN ? 32'h1 : 32'h0);
    xfer(0, 1'b0, 32'h20, 32'h0, 4'hF, 0);
    chk("mis_wr_nowrite", r_dat, 32'h11FF_33FF);

    // Slow master holds stb for 4 cycles after ack.
    xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, 4);
    chk("slow_data", r_dat, 32'hA5A5_1234);
    chk("slow_single_ack", 32'(r_extra), 32'd0);
    xfer(0, 1'b0, 32'h0, 32'h0, 4'hF, 0);
    chk("slow_next_latency", 32'(r_lat), 32'd3);
    chk("slow_next_data", r_dat, 32'h00C0_FFEE);

    // WAIT_STATES = 3.
    xfer(1, 1'b1, 32'h40, 32'h1357_9BDF, 4'hF, 0);
    chk("ws3_latency", 32'(r_lat), 32'd5);
    xfer(1, 1'b1, 32'h44, 32'h2468_ACE0, 4'hF, 0);

    // Abort: cyc drops while waiting.
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h40;
    wd[1] = 32'hCAFE_0000; sel[1] = 4'hF;
    tick();
    tick();
    bus_idle(1);
    r_extra = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ack[1] || err[1]) r_extra++;
    end
    chk("abort_no_term", 32'(r_extra), 32'd0);
    xfer(1, 1'b0, 32'h40, 32'h0, 4'hF, 0);
    chk("abort_no_write", r_dat, 32'h1357_9BDF);

    // Reset while waiting: outputs clear without a clock edge, no write.
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h44;
    wd[1] = 32'hCAFE_0000; sel[1] = 4'hF;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_dat", rd[1], 32'h0);
    chk("rst_mid_ack", {31'b0, ack[1]}, 32'h0);
    chk("rst_mid_err", {31'b0, err[1]}, 32'h0);
    tick();
    tick();
    bus_idle(1);
    tick();
    rst = 1'b0;
    tick();
    xfer(1, 1'b0, 32'h44, 32'h0, 4'hF, 0);
    chk("rst_mid_no_write", r_dat, 32'h2468_ACE0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
